frame_sequencer: RTL and testbench

Per-frame update scheduler for the pingpong game. Detects each rising edge of the divided frame clock (about 60 Hz) and runs the game's update stages (paddle, ball, collision, score) one at a time in fixed order, using a start/done handshake with each stage. Sits between the frame clock divider and the game-logic stage blocks. Reports frame overruns and hung stages through sticky error flags.

---
 rtl/frame_sequencer.sv | 148 ++++++++++++++
 tb/tb_frame_sequencer.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : frame_sequencer
// Purpose  : Runs the per-frame game update stages in order on each frame
//            clock rising edge, with sticky overrun/timeout error flags.
// Revision : 1.0
// ============================================================================
module frame_sequencer #(
    parameter int NUM_STAGES    = 4,
    parameter int STAGE_TIMEOUT = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  frame_clk,
    input  logic                  pause,
    input  logic                  clear_err,
    input  logic [NUM_STAGES-1:0] done,
    output logic [NUM_STAGES-1:0] start,
    output logic                  busy,
    output logic [15:0]           frame_cnt,
    output logic                  overrun,
    output logic                  timeout
);

    localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_issue = 2'd1;
    localparam logic [1:0] c_st_wait  = 2'd2;

    localparam logic [IDX_W-1:0] c_last_idx  = IDX_W'(NUM_STAGES - 1);
    localparam logic [15:0]      c_wait_last = 16'(STAGE_TIMEOUT - 1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_idx_nxt;
    logic [15:0]      r_wait_cnt;
    logic [15:0]      r_frame_cnt;
    logic             r_frame_clk_d;
    logic             r_overrun;
    logic             r_timeout;

    logic w_frame_evt;
    logic w_in_wait;
    logic w_cnt_last;
    logic w_stage_done;
    logic w_expired;
    logic w_frame_done;

    assign w_frame_evt  = frame_clk & ~r_frame_clk_d;
    assign w_in_wait    = (r_state == c_st_wait);
    assign w_cnt_last   = (r_wait_cnt == c_wait_last);
    // A done arriving on the expiry cycle wins over the timeout.
    assign w_stage_done = w_in_wait && (done[r_idx] || w_cnt_last);
    assign w_expired    = w_in_wait && !done[r_idx] && w_cnt_last;
    assign w_frame_done = w_stage_done && (r_idx == c_last_idx);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        case (r_state)
            c_st_idle: begin
                if (w_frame_evt && !pause) begin
                    w_state_nxt = c_st_issue;
                    w_idx_nxt   = '0;
                end
            end
            c_st_issue: begin
                w_state_nxt = c_st_wait;
            end
            c_st_wait: begin
                if (w_stage_done) begin
                    if (r_idx == c_last_idx) begin
                        w_state_nxt = c_st_idle;
                        w_idx_nxt   = '0;
                    end else begin
                        w_state_nxt = c_st_issue;
                        w_idx_nxt   = r_idx + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
                w_idx_nxt   = '0;
            end
        endcase
    end

    // Outputs decode registered state only, so nothing reaches them from inputs.
    always_comb begin
        start = '0;
        busy  = (r_state != c_st_idle);
        if (r_state == c_st_issue) begin
            start[r_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_idx         <= '0;
            r_wait_cnt    <= '0;
            r_frame_cnt   <= '0;
            r_frame_clk_d <= 1'b1;
            r_overrun     <= 1'b0;
            r_timeout     <= 1'b0;
        end else begin
            r_idx         <= w_idx_nxt;
            r_frame_clk_d <= frame_clk;

            if (r_state == c_st_issue) begin
                r_wait_cnt <= '0;
            end else if (w_in_wait) begin
                r_wait_cnt <= r_wait_cnt + 16'd1;
            end

            if (w_frame_done) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end

            if (w_frame_evt && (r_state != c_st_idle)) begin
                r_overrun <= 1'b1;
            end else if (clear_err) begin
                r_overrun <= 1'b0;
            end

            if (w_expired) begin
                r_timeout <= 1'b1;
            end else if (clear_err) begin
                r_timeout <= 1'b0;
            end
        end
    end

    assign frame_cnt = r_frame_cnt;
    assign overrun   = r_overrun;
    assign timeout   = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_frame_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_frame_sequencer
// Purpose  : Self-checking bench for frame_sequencer; start pulses are
//            scoreboarded against a schedule model of each frame.
// Revision : 1.0
// ============================================================================
module tb_frame_sequencer;

    localparam int NS = 4;
    localparam int TO = 8;

    typedef struct {
        int         cyc;
        logic [3:0] val;
    } start_t;

    logic        clk        = 1'b0;
    logic        reset      = 1'b0;
    logic        frame_clk  = 1'b0;
    logic        pause      = 1'b0;
    logic        clear_err  = 1'b0;
    logic [3:0]  resp_done  = 4'b0;
    logic [3:0]  stray_done = 4'b0;
    logic [3:0]  done;
    logic [3:0]  start;
    logic        busy;
    logic [15:0] frame_cnt;
    logic        overrun;
    logic        timeout;

    int          cyc       = 0;
    int          n_checks  = 0;
    int          n_pass    = 0;
    int          lat[NS];
    int          resp_left = 0;
    int          resp_k    = 0;
    logic [15:0] exp_cnt   = 16'd0;
    start_t      exp_q[$];
    start_t      mon_e;

    assign done = resp_done | stray_done;

    frame_sequencer #(
        .NUM_STAGES   (NS),
        .STAGE_TIMEOUT(TO)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .frame_clk(frame_clk),
        .pause    (pause),
        .clear_err(clear_err),
        .done     (done),
        .start    (start),
        .busy     (busy),
        .frame_cnt(frame_cnt),
        .overrun  (overrun),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stage model: answers start[k] with done[k] lat[k] cycles later (0 = never).
    always @(negedge clk) begin
        resp_done = 4'b0;
        if (reset !== 1'b1) begin
            resp_left = 0;
        end else begin
            if (resp_left > 0) begin
                resp_left = resp_left - 1;
                if (resp_left == 0) resp_done = 4'(1 << resp_k);
            end
            for (int k = 0; k < NS; k++) begin
                if (start[k] === 1'b1 && lat[k] > 0) begin
                    resp_left = lat[k];
                    resp_k    = k;
                end
            end
        end
    end

    // Scoreboard consumer: every start pulse must match the next expected one.
    always @(negedge clk) begin
        if (reset === 1'b1 && start !== 4'b0) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL start_unexpected cycle %0d got %b want none", cyc, start);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.cyc != cyc || mon_e.val !== start)
                    $display("FAIL start_sched got %b at %0d want %b at %0d",
                             start, cyc, mon_e.val, mon_e.cyc);
                else
                    n_pass++;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Expected start schedule for a frame whose event is in cycle t.
    task automatic push_frame(input int t, output int t_end);
        int     s;
        int     w;
        start_t e;
        s = t + 1;
        for (int k = 0; k < NS; k++) begin
            e.cyc = s;
            e.val = 4'(1 << k);
            exp_q.push_back(e);
            w = (lat[k] == 0 || lat[k] > TO) ? TO : lat[k];
            s = s + 1 + w;
        end
        t_end = s;
    endtask

    task automatic run_frame(input int ovr_off, input bit with_stray, input bit pause_mid);
        int t0;
        int t_end;
        int off;
        t0 = cyc;
        push_frame(t0, t_end);
        while (cyc < t_end) begin
            off        = cyc - t0;
            frame_clk  = (off == 0) || (off == ovr_off);
            clear_err  = (off == ovr_off);
            stray_done = !with_stray ? 4'b0 : (off == 1) ? 4'b0001 : (off == 2) ? 4'b1000 : 4'b0;
            pause      = pause_mid && (off >= 3);
            n_checks++;
            if (busy !== (off >= 1) || frame_cnt !== exp_cnt)
                $display("FAIL frame_cycle off %0d busy %b cnt %0d want busy %b cnt %0d",
                         off, busy, frame_cnt, (off >= 1), exp_cnt);
            else
                n_pass++;
            step(1);
        end
        frame_clk  = 1'b0;
        clear_err  = 1'b0;
        stray_done = 4'b0;
        pause      = 1'b0;
        exp_cnt    = exp_cnt + 16'd1;
        n_checks++;
        if (busy !== 1'b0 || frame_cnt !== exp_cnt)
            $display("FAIL frame_end busy %b cnt %0d want busy 0 cnt %0d", busy, frame_cnt, exp_cnt);
        else
            n_pass++;
        step(2);
        n_checks++;
        if (busy !== 1'b0 || exp_q.size() != 0)
            $display("FAIL frame_idle busy %b pending %0d want busy 0 pending 0", busy, exp_q.size());
        else
            n_pass++;
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        frame_clk = 1'b1;
        step(3);
        n_checks++;
        if (start !== 4'b0 || busy !== 1'b0 || frame_cnt !== 16'd0 || overrun !== 1'b0 || timeout !== 1'b0)
            $display("FAIL reset_values got start %b busy %b cnt %0d ovr %b to %b want all 0",
                     start, busy, frame_cnt, overrun, timeout);
        else
            n_pass++;
        reset = 1'b1;
        step(4);
        n_checks++;
        if (busy !== 1'b0) $display("FAIL reset_release_high busy %b want 0", busy);
        else n_pass++;
        frame_clk = 1'b0;
        step(2);
    endtask

    task automatic test_normal_frame();
        lat = '{3, 3, 3, 3};
        run_frame(-1, 1'b0, 1'b0);
        n_checks++;
        if (overrun !== 1'b0 || timeout !== 1'b0)
            $display("FAIL normal_flags ovr %b to %b want 0 0", overrun, timeout);
        else
            n_pass++;
    endtask

    task automatic test_overrun();
        lat = '{3, 3, 3, 3};
        // Second edge lands in stage 2 WAIT, together with a clear_err pulse.
        run_frame(11, 1'b0, 1'b0);
        n_checks++;
        if (overrun !== 1'b1) $display("FAIL overrun_set got %b want 1", overrun);
        else n_pass++;
        clear_err = 1'b1;
        step(1);
        clear_err = 1'b0;
        n_checks++;
        if (overrun !== 1'b0 || timeout !== 1'b0)
            $display("FAIL overrun_clear ovr %b to %b want 0 0", overrun, timeout);
        else
            n_pass++;
        step(1);
    endtask

    task automatic test_timeout();
        lat = '{1, 0, 1, 1};
        run_frame(-1, 1'b0, 1'b0);
        n_checks++;
        if (timeout !== 1'b1) $display("FAIL timeout_set got %b want 1", timeout);
        else n_pass++;
        clear_err = 1'b1;
        step(1);
        clear_err = 1'b0;
        n_checks++;
        if (timeout !== 1'b0) $display("FAIL timeout_clear got %b want 0", timeout);
        else n_pass++;
        step(1);
        lat = '{1, TO, 1, 1};
        run_frame(-1, 1'b0, 1'b0);
        n_checks++;
        if (timeout !== 1'b0) $display("FAIL timeout_last_cycle_done got %b want 0", timeout);
        else n_pass++;
    endtask

    task automatic test_pause_stray();
        lat        = '{3, 3, 3, 3};
        stray_done = 4'b1111;
        step(1);
        stray_done = 4'b0;
        pause      = 1'b1;
        frame_clk  = 1'b1;
        step(1);
        frame_clk  = 1'b0;
        pause      = 1'b0;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL pause_busy got %b want 0", busy);
        else n_pass++;
        step(4);
        n_checks++;
        if (busy !== 1'b0 || frame_cnt !== exp_cnt)
            $display("FAIL pause_skip busy %b cnt %0d want busy 0 cnt %0d", busy, frame_cnt, exp_cnt);
        else
            n_pass++;
        run_frame(-1, 1'b1, 1'b1);
    endtask

    task automatic test_reset_mid_frame();
        int t0;
        int t_end;
        lat = '{3, 0, 3, 3};
        t0  = cyc;
        push_frame(t0, t_end);
        void'(exp_q.pop_back());
        frame_clk = 1'b1;
        while (cyc < t0 + 16) step(1);
        n_checks++;
        if (timeout !== 1'b1 || busy !== 1'b1)
            $display("FAIL pre_reset to %b busy %b want 1 1", timeout, busy);
        else
            n_pass++;
        reset = 1'b0;
        step(1);
        exp_cnt = 16'd0;
        n_checks++;
        if (start !== 4'b0 || busy !== 1'b0 || frame_cnt !== 16'd0 || overrun !== 1'b0 || timeout !== 1'b0)
            $display("FAIL mid_reset got start %b busy %b cnt %0d ovr %b to %b want all 0",
                     start, busy, frame_cnt, overrun, timeout);
        else
            n_pass++;
        step(1);
        reset = 1'b1;
        step(4);
        n_checks++;
        if (busy !== 1'b0 || exp_q.size() != 0)
            $display("FAIL held_high busy %b pending %0d want 0 0", busy, exp_q.size());
        else
            n_pass++;
        frame_clk = 1'b0;
        lat       = '{3, 3, 3, 3};
        step(1);
        run_frame(-1, 1'b0, 1'b0);
    endtask

    task automatic test_wrap();
        lat = '{1, 1, 1, 1};
        force dut.r_frame_cnt = 16'hFFFF;
        step(1);
        release dut.r_frame_cnt;
        step(1);
        exp_cnt = 16'hFFFF;
        n_checks++;
        if (frame_cnt !== exp_cnt) $display("FAIL wrap_preload got %0d want %0d", frame_cnt, exp_cnt);
        else n_pass++;
        run_frame(-1, 1'b0, 1'b0);
        n_checks++;
        if (frame_cnt !== 16'd0) $display("FAIL wrap_zero got %0d want 0", frame_cnt);
        else n_pass++;
    endtask

    initial begin
        lat = '{3, 3, 3, 3};
        test_reset();
        test_normal_frame();
        test_overrun();
        test_timeout();
        test_pause_stray();
        test_reset_mid_frame();
        test_wrap();
        step(2);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
